decimal2bcd_key_encoder: RTL and testbench

Debounced decimal-keypad encoder: converts ten decimal key lines into a 4-bit BCD code, emitting one code per key press over a valid/ready handshake and shifting accepted digits into a multi-digit BCD entry register. It is the encode-side counterpart of the BCD-to-decimal decoder and sits between a keypad front end and BCD display or arithmetic logic.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/encoder_decimal2bcd.sv | 26 ++
 rtl/decimal2bcd_key_encoder.sv | 193 +++++++++++++++++++
 tb/tb_decimal2bcd_key_encoder.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the decimal keypad to BCD encoder.
package bcd_pkg;

    // Number of decimal key lines (keys 0..9).
    localparam int NUM_KEYS = 10;

    // One BCD digit, legal values 0..9.
    typedef logic [3:0] bcd_digit_t;

    // Key encoder control states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

endpackage

// File: rtl/encoder_decimal2bcd.sv
// Combinational 10-line to BCD encoder. When several lines are high, the
// highest index wins. Also reports multi-hot and all-zero inputs.
module encoder_decimal2bcd
    import bcd_pkg::*;
(
    input  logic [9:0] keys,
    output logic [3:0] code,
    output logic       multi,
    output logic       none
);

    // Priority encode: later (higher) indices overwrite earlier ones.
    always_comb begin
        code = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keys[i]) begin
                code = bcd_digit_t'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = (keys & (keys - 10'd1)) != 10'd0;
    assign none  = (keys == 10'd0);

endmodule

// File: rtl/decimal2bcd_key_encoder.sv
// Debounced decimal keypad encoder with a valid/ready output and a
// multi-digit BCD entry shift register.
// Optional feature macro: MULTIKEY_ERR_EN (reject multi-key presses, pulse err).
//
// Handshake: bcd_out/bcd_valid are held stable while bcd_valid=1; a code is
// transferred on every rising edge where bcd_valid && bcd_ready; bcd_ready is
// don't-care while bcd_valid=0.
module decimal2bcd_key_encoder
    import bcd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DIGITS          = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            key_in,
    output logic [3:0]            bcd_out,
    output logic                  bcd_valid,
    input  logic                  bcd_ready,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic                  ovf,
    output logic                  err
);

    localparam int DW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [9:0]       sample, sample_nxt;
    logic             done;
    logic             reject;
    logic             load_code;
    logic             err_set;
    logic             accept;
    bcd_digit_t       enc_code;
    logic             enc_multi;
    logic             enc_none;

    // Encode the sample being latched this cycle, so a press that completes
    // on the same edge it is first seen (DEBOUNCE_CYCLES=1) encodes correctly.
    encoder_decimal2bcd u_enc (
        .keys  (sample_nxt),
        .code  (enc_code),
        .multi (enc_multi),
        .none  (enc_none)
    );

`ifdef MULTIKEY_ERR_EN
    assign reject = enc_multi;
`else
    logic multi_unused;
    assign multi_unused = enc_multi;
    assign reject       = 1'b0;
`endif

    assign accept    = (state == EMIT) && bcd_ready;
    assign load_code = done && !reject && !enc_none;
    assign err_set   = done && reject;

    // State register plus debounce counter and latched key sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sample <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sample <= sample_nxt;
        end
    end

    // Next-state logic: debounce presses, hold for handshake, debounce release.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        sample_nxt = sample;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (key_in != 10'd0) begin
                    sample_nxt = key_in;
                    cnt_nxt    = CNT_ONE;
                    state_nxt  = DEBOUNCE;
                    done       = (CNT_ONE >= CNT_MAX);
                end
            end
            DEBOUNCE: begin
                if (key_in == 10'd0) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (key_in == sample) begin
                    cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                    done    = (cnt_nxt >= CNT_MAX);
                end else begin
                    sample_nxt = key_in;
                    cnt_nxt    = CNT_ONE;
                    done       = (CNT_ONE >= CNT_MAX);
                end
            end
            EMIT: begin
                // Key activity is ignored until the code is taken.
                if (bcd_ready) begin
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (key_in == 10'd0) begin
                    cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                    if (cnt_nxt >= CNT_MAX) begin
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase

        // A completed debounce either emits a code or is rejected.
        if (done) begin
            cnt_nxt = '0;
            if (reject) begin
                state_nxt = RELEASE;
            end else if (!enc_none) begin
                state_nxt = EMIT;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    // Output decode: a code is pending exactly while in EMIT.
    always_comb begin
        bcd_valid = (state == EMIT);
    end

    // Output code register and entry shift register with sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_out    <= 4'd0;
            digits_out <= '0;
            ovf        <= 1'b0;
        end else begin
            if (load_code) begin
                bcd_out <= enc_code;
            end
            if (accept) begin
                if (clear) begin
                    digits_out <= DW'(bcd_out);
                    ovf        <= 1'b0;
                end else begin
                    digits_out <= (digits_out << 4) | DW'(bcd_out);
                    if (digits_out[DW-1 -: 4] != 4'd0) begin
                        ovf <= 1'b1;
                    end
                end
            end else if (clear) begin
                digits_out <= '0;
                ovf        <= 1'b0;
            end
        end
    end

`ifdef MULTIKEY_ERR_EN
    logic err_q;

    // One-cycle pulse on a rejected multi-key press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_set;
        end
    end

    assign err = err_q;
`else
    logic err_set_unused;
    assign err_set_unused = err_set;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_decimal2bcd_key_encoder.sv
// Self-checking bench for decimal2bcd_key_encoder (default parameters).
module tb_decimal2bcd_key_encoder;
  localparam int DC = 4;
  localparam int DIGITS = 4;
  localparam int DW = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    key_in = '0;
  logic [3:0]    bcd_out;
  logic          bcd_valid;
  logic          bcd_ready = 1'b0;
  logic          clear = 1'b0;
  logic [DW-1:0] digits_out;
  logic          ovf;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic [3:0]    exp_q[$];
  logic [DW-1:0] exp_digits = '0;
  logic          exp_ovf = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  decimal2bcd_key_encoder #(
    .DEBOUNCE_CYCLES(DC),
    .DIGITS(DIGITS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_in(key_in),
    .bcd_out(bcd_out),
    .bcd_valid(bcd_valid),
    .bcd_ready(bcd_ready),
    .clear(clear),
    .digits_out(digits_out),
    .ovf(ovf),
    .err(err)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int k);
    key_in = '0;
    key_in[k] = 1'b1;
    exp_q.push_back(4'(k));
  endtask

  task automatic release_key();
    key_in = '0;
    repeat (DC + 2) step();
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (bcd_valid === 1'b1) begin
        cyc = i + 1;
        break;
      end
    end
  endtask

  // Reference model of the entry register on an accept.
  task automatic model_accept(input logic [3:0] code, input logic clr);
    if (clr) begin
      exp_digits = DW'(code);
      exp_ovf = 1'b0;
    end else begin
      if (exp_digits[DW-1 -: 4] != 4'd0) exp_ovf = 1'b1;
      exp_digits = (exp_digits << 4) | DW'(code);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; key_in = '0; bcd_ready = 1'b0; clear = 1'b0;
    repeat (2) step();
    checks++;
    if ({bcd_valid, bcd_out, ovf, err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b out=%h ovf=%b err=%b expected all 0", bcd_valid, bcd_out, ovf, err);
    end
    checks++;
    if (digits_out !== '0) begin
      errors++;
      $display("FAIL reset_digits: got %h expected 0", digits_out);
    end
    rst_n = 1'b1;
    exp_digits = '0; exp_ovf = 1'b0;
    step();
  endtask

  task automatic test_single_press();
    logic [3:0] got;
    bcd_ready = 1'b1;
    press(5);
    repeat (DC - 1) step();
    checks++;
    if (bcd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid: got %b expected 0", bcd_valid);
    end
    step();
    checks++;
    if (bcd_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: got valid %b expected 1 after edge %0d", bcd_valid, DC);
    end
    got = exp_q.pop_front();
    checks++;
    if (bcd_out !== got) begin
      errors++;
      $display("FAIL single_code: got %h expected %h", bcd_out, got);
    end
    step();
    model_accept(got, 1'b0);
    checks++;
    if (digits_out !== exp_digits || bcd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: got digits %h valid %b expected %h 0", digits_out, bcd_valid, exp_digits);
    end
    bcd_ready = 1'b0;
    release_key();
  endtask

  task automatic test_hold_ready();
    int cyc;
    int extra;
    logic stable_ok;
    logic [3:0] got;
    bcd_ready = 1'b0;
    press(9);
    wait_valid(DC + 4, cyc);
    checks++;
    if (cyc != DC) begin
      errors++;
      $display("FAIL hold_latency: got %0d cycles expected %0d", cyc, DC);
    end
    key_in = '0;
    stable_ok = 1'b1;
    repeat (6) begin
      step();
      if (bcd_valid !== 1'b1 || bcd_out !== 4'd9) stable_ok = 1'b0;
    end
    checks++;
    if (!stable_ok) begin
      errors++;
      $display("FAIL hold_stable: got valid %b out %h expected 1 9", bcd_valid, bcd_out);
    end
    got = exp_q.pop_front();
    checks++;
    if (bcd_out !== got) begin
      errors++;
      $display("FAIL hold_code: got %h expected %h", bcd_out, got);
    end
    bcd_ready = 1'b1;
    step();
    bcd_ready = 1'b0;
    model_accept(got, 1'b0);
    checks++;
    if (digits_out !== exp_digits || bcd_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_accept: got digits %h valid %b expected %h 0", digits_out, bcd_valid, exp_digits);
    end
    extra = 0;
    bcd_ready = 1'b1;
    repeat (2 * DC + 4) begin
      step();
      if (bcd_valid === 1'b1) extra++;
    end
    bcd_ready = 1'b0;
    checks++;
    if (extra != 0 || digits_out !== exp_digits) begin
      errors++;
      $display("FAIL hold_single_accept: got %0d extra valid cycles digits %h expected 0 %h", extra, digits_out, exp_digits);
    end
  endtask

  task automatic test_bounce();
    int cyc;
    int seen;
    logic [3:0] got;
    seen = 0;
    repeat (3) begin
      key_in = 10'b00_0000_0100;
      step(); if (bcd_valid === 1'b1) seen++;
      step(); if (bcd_valid === 1'b1) seen++;
      key_in = '0;
      step(); if (bcd_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL bounce_no_valid: got %0d valid cycles expected 0", seen);
    end
    press(2);
    wait_valid(DC + 4, cyc);
    checks++;
    if (cyc != DC) begin
      errors++;
      $display("FAIL bounce_latency: got %0d cycles expected %0d", cyc, DC);
    end
    got = exp_q.pop_front();
    checks++;
    if (bcd_out !== got) begin
      errors++;
      $display("FAIL bounce_code: got %h expected %h", bcd_out, got);
    end
    bcd_ready = 1'b1;
    step();
    bcd_ready = 1'b0;
    model_accept(got, 1'b0);
    release_key();
  endtask

  task automatic test_sequence();
    int cyc;
    logic [3:0] got;
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_digits = '0; exp_ovf = 1'b0;
    checks++;
    if (digits_out !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL seq_pre_clear: got %h ovf %b expected 0 0", digits_out, ovf);
    end
    for (int k = 1; k <= 5; k++) begin
      press(k);
      wait_valid(DC + 4, cyc);
      got = exp_q.pop_front();
      checks++;
      if (bcd_valid !== 1'b1 || bcd_out !== got) begin
        errors++;
        $display("FAIL seq_code: got valid %b out %h expected 1 %h", bcd_valid, bcd_out, got);
      end
      bcd_ready = 1'b1;
      step();
      bcd_ready = 1'b0;
      model_accept(got, 1'b0);
      release_key();
    end
    checks++;
    if (digits_out !== 16'h2345 || ovf !== 1'b1 || digits_out !== exp_digits || ovf !== exp_ovf) begin
      errors++;
      $display("FAIL seq_digits: got %h ovf %b expected 2345 1", digits_out, ovf);
    end
    // clear and accept on the same edge
    press(6);
    wait_valid(DC + 4, cyc);
    got = exp_q.pop_front();
    clear = 1'b1;
    bcd_ready = 1'b1;
    step();
    clear = 1'b0;
    bcd_ready = 1'b0;
    model_accept(got, 1'b1);
    checks++;
    if (digits_out !== exp_digits || ovf !== 1'b0) begin
      errors++;
      $display("FAIL clear_accept: got %h ovf %b expected %h 0", digits_out, ovf, exp_digits);
    end
    release_key();
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_digits = '0; exp_ovf = 1'b0;
    checks++;
    if (digits_out !== '0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL clear_plain: got %h ovf %b expected 0 0", digits_out, ovf);
    end
  endtask

  task automatic test_multikey();
    int pulses;
    int vseen;
`ifdef MULTIKEY_ERR_EN
    pulses = 0; vseen = 0;
    bcd_ready = 1'b1;
    key_in = 10'b00_1000_1000;
    repeat (DC + 4) begin
      step();
      if (err === 1'b1) pulses++;
      if (bcd_valid === 1'b1) vseen++;
    end
    bcd_ready = 1'b0;
    checks++;
    if (pulses != 1 || vseen != 0) begin
      errors++;
      $display("FAIL multikey_reject: got %0d err pulses %0d valid cycles expected 1 0", pulses, vseen);
    end
    release_key();
`else
    int cyc;
    logic [3:0] got;
    pulses = 0; vseen = 0;
    key_in = 10'b00_1000_1000;
    exp_q.push_back(4'd7);
    wait_valid(DC + 4, cyc);
    got = exp_q.pop_front();
    checks++;
    if (bcd_valid !== 1'b1 || bcd_out !== got) begin
      errors++;
      $display("FAIL multikey_priority: got valid %b out %h expected 1 %h", bcd_valid, bcd_out, got);
    end
    bcd_ready = 1'b1;
    step();
    bcd_ready = 1'b0;
    model_accept(got, 1'b0);
    checks++;
    if (digits_out !== exp_digits || err !== 1'b0) begin
      errors++;
      $display("FAIL multikey_accept: got digits %h err %b expected %h 0", digits_out, err, exp_digits);
    end
    release_key();
`endif
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic [3:0] got;
    bcd_ready = 1'b0;
    press(4);
    wait_valid(DC + 4, cyc);
    rst_n = 1'b0;
    step();
    checks++;
    if ({bcd_valid, bcd_out, ovf, err} !== 7'b0 || digits_out !== '0) begin
      errors++;
      $display("FAIL reset_mid: got valid %b out %h digits %h ovf %b err %b expected 0", bcd_valid, bcd_out, digits_out, ovf, err);
    end
    exp_q.delete();
    exp_digits = '0; exp_ovf = 1'b0;
    exp_q.push_back(4'd4);
    rst_n = 1'b1;
    wait_valid(DC + 4, cyc);
    checks++;
    if (cyc != DC) begin
      errors++;
      $display("FAIL reset_redebounce: got %0d cycles expected %0d", cyc, DC);
    end
    got = exp_q.pop_front();
    bcd_ready = 1'b1;
    checks++;
    if (bcd_out !== got) begin
      errors++;
      $display("FAIL reset_code: got %h expected %h", bcd_out, got);
    end
    step();
    bcd_ready = 1'b0;
    model_accept(got, 1'b0);
    checks++;
    if (digits_out !== exp_digits) begin
      errors++;
      $display("FAIL reset_accept: got %h expected %h", digits_out, exp_digits);
    end
    release_key();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_press();
    test_hold_ready();
    test_bounce();
    test_sequence();
    test_multikey();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
